// File: rtl/ps2_kbd_cmd_sequencer.sv
// Host-side PS/2 keyboard command sequencer: runs reset/BAT (0xFF) and set-LED (0xED+arg)
// exchanges through PS2_Controller and forwards all other received bytes. Optional: AUTO_INIT_EN.
module ps2_kbd_cmd_sequencer #(
  parameter int RSP_TIMEOUT = 2_500_000,
  parameter int BAT_TIMEOUT = 50_000_000,
  parameter int MAX_RETRIES = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       busy,
  output logic       init_done,
  output logic       error,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] key_data,
  output logic       key_data_en
);

  localparam int TMAX = (RSP_TIMEOUT > BAT_TIMEOUT) ? RSP_TIMEOUT : BAT_TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TW-1:0] RSP_LAST  = TW'(RSP_TIMEOUT - 1);
  localparam logic [TW-1:0] BAT_LAST  = TW'(BAT_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

`ifdef AUTO_INIT_EN
  localparam logic AUTO_INIT = 1'b1;
`else
  localparam logic AUTO_INIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_WAIT_BAT, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [2:0]      arg_q, arg_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pend_q, pend_d;
  logic            busy_q, busy_d;
  logic            init_done_q, init_done_d;
  logic            error_q, error_d;
  logic [7:0]      the_command_q, the_command_d;
  logic            send_q, send_d;
  logic [7:0]      key_data_q, key_data_d;
  logic            key_data_en_q, key_data_en_d;
  logic            consumed;
  logic            start;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    arg_d         = arg_q;
    retry_d       = retry_q;
    timer_d       = timer_q;
    pend_d        = pend_q;
    busy_d        = busy_q;
    init_done_d   = init_done_q;
    error_d       = error_q;
    the_command_d = the_command_q;
    send_d        = send_q;
    key_data_d    = key_data_q;
    key_data_en_d = 1'b0;
    consumed      = 1'b0;
    start         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // init has priority; a simultaneous led_req is dropped, not queued
        if (init_req || pend_q) begin
          cmd_d       = CMD_RESET;
          init_done_d = 1'b0;
          pend_d      = 1'b0;
          start       = 1'b1;
        end else if (led_req) begin
          cmd_d = CMD_SET_LED;
          arg_d = led_val;
          start = 1'b1;
        end
        if (start) begin
          error_d = 1'b0;
          busy_d  = 1'b1;
          retry_d = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        the_command_d = cmd_q;
        send_d        = 1'b1;
        state_d       = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (command_was_sent) begin
          send_d  = 1'b0;
          state_d = S_WAIT_ACK;
        end else if (error_communication_timed_out) begin
          state_d = S_ERROR;
        end
      end
      S_WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        if (received_data_en && (received_data == RSP_ACK || received_data == RSP_RESEND)) begin
          consumed = 1'b1;
          if (received_data == RSP_ACK) begin
            if (cmd_q == CMD_RESET) begin
              state_d = S_WAIT_BAT;
            end else if (cmd_q == CMD_SET_LED) begin
              cmd_d   = {5'b0, arg_q};
              retry_d = '0;
              state_d = S_SEND;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_SEND;
          end else begin
            state_d = S_ERROR;
          end
        end else if (timer_q == RSP_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_WAIT_BAT: begin
        timer_d = timer_q + 1'b1;
        if (received_data_en && received_data == RSP_BAT_OK) begin
          consumed    = 1'b1;
          init_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (received_data_en && received_data == RSP_BAT_FAIL) begin
          consumed = 1'b1;
          state_d  = S_ERROR;
        end else if (timer_q == BAT_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // error flags are registered together with the ERROR state itself
    if (state_d == S_ERROR) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
      send_d  = 1'b0;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end

    if (received_data_en && !consumed) begin
      key_data_en_d = 1'b1;
      key_data_d    = received_data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cmd_q         <= 8'h00;
      arg_q         <= 3'b000;
      retry_q       <= '0;
      timer_q       <= '0;
      pend_q        <= AUTO_INIT;
      busy_q        <= 1'b0;
      init_done_q   <= 1'b0;
      error_q       <= 1'b0;
      the_command_q <= 8'h00;
      send_q        <= 1'b0;
      key_data_q    <= 8'h00;
      key_data_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      arg_q         <= arg_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      pend_q        <= pend_d;
      busy_q        <= busy_d;
      init_done_q   <= init_done_d;
      error_q       <= error_d;
      the_command_q <= the_command_d;
      send_q        <= send_d;
      key_data_q    <= key_data_d;
      key_data_en_q <= key_data_en_d;
    end
  end

  assign busy         = busy_q;
  assign init_done    = init_done_q;
  assign error        = error_q;
  assign the_command  = the_command_q;
  assign send_command = send_q;
  assign key_data     = key_data_q;
  assign key_data_en  = key_data_en_q;

endmodule

// File: tb/tb_ps2_kbd_cmd_sequencer.sv
// Self-checking bench for ps2_kbd_cmd_sequencer (default build, AUTO_INIT_EN undefined).
module tb_ps2_kbd_cmd_sequencer;

  localparam int RSP_TO = 20;
  localparam int BAT_TO = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       init_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       busy, init_done, error;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic [7:0] key_data;
  logic       key_data_en;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_cmd[$];
  logic [7:0] exp_key[$];
  logic [7:0] exp_c, exp_k;
  logic       send_prev = 1'b0;

  ps2_kbd_cmd_sequencer #(
    .RSP_TIMEOUT(RSP_TO), .BAT_TIMEOUT(BAT_TO), .MAX_RETRIES(3)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .init_req(init_req), .led_req(led_req),
    .led_val(led_val), .busy(busy), .init_done(init_done), .error(error),
    .the_command(the_command), .send_command(send_command),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .received_data(received_data), .received_data_en(received_data_en),
    .key_data(key_data), .key_data_en(key_data_en)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every new transmit request must match the next expected command byte
  always @(negedge clk) begin
    if (send_command === 1'b1 && send_prev !== 1'b1) begin
      checks++;
      if (exp_cmd.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: sent %02h, required no send", the_command);
      end else begin
        exp_c = exp_cmd.pop_front();
        if (the_command !== exp_c) begin
          errors++;
          $display("FAIL cmd_byte: sent %02h, required %02h", the_command, exp_c);
        end
      end
    end
    send_prev <= send_command;
  end

  // Scoreboard: every forwarded byte must match the next expected scan byte
  always @(negedge clk) begin
    if (key_data_en === 1'b1) begin
      checks++;
      if (exp_key.size() == 0) begin
        errors++;
        $display("FAIL key_unexpected: key_data %02h, required no forward", key_data);
      end else begin
        exp_k = exp_key.pop_front();
        if (key_data !== exp_k) begin
          errors++;
          $display("FAIL key_byte: key_data %02h, required %02h", key_data, exp_k);
        end
      end
    end
  end

  task automatic pulse_init();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
  endtask

  task automatic pulse_led(input logic [2:0] v);
    @(negedge clk) begin led_req = 1'b1; led_val = v; end
    @(negedge clk) led_req = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int n;
    n = 0;
    while (send_command !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (send_command !== 1'b1) begin
      errors++;
      $display("FAIL %s_tx_wait: send_command=%b, required 1 within 50 cycles", tag, send_command);
    end
  endtask

  task automatic tx_ack(input string tag);
    wait_send(tag);
    command_was_sent = 1'b1;
    @(negedge clk) command_was_sent = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk) begin received_data = b; received_data_en = 1'b1; end
    @(negedge clk) received_data_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, init_done, error, send_command, key_data_en} !== 5'b0 || the_command !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy/init_done/error/send/key_en=%b cmd=%02h, required 00000 cmd=00",
               {busy, init_done, error, send_command, key_data_en}, the_command);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (send_command !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: send=%b busy=%b, required 0 0 without request", send_command, busy);
    end
  endtask

  task automatic test_init();
    exp_cmd.push_back(8'hFF);
    pulse_init();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: busy=%b, required 1", busy); end
    tx_ack("init");
    rx_byte(8'hFA);
    checks++;
    if (busy !== 1'b1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL init_wait_bat: busy=%b init_done=%b, required 1 0", busy, init_done);
    end
    rx_byte(8'hAA);
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL init_done: init_done=%b busy=%b error=%b, required 1 0 0", init_done, busy, error);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_cmd.size() != 0 || exp_key.size() != 0) begin
      errors++;
      $display("FAIL init_queues: cmd pending %0d key pending %0d, required 0 0", exp_cmd.size(), exp_key.size());
    end
  endtask

  task automatic test_led();
    exp_cmd.push_back(8'hED);
    exp_cmd.push_back(8'h05);
    pulse_led(3'b101);
    tx_ack("led1");
    rx_byte(8'hFA);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL led_mid_busy: busy=%b, required 1", busy); end
    tx_ack("led2");
    rx_byte(8'hFA);
    checks++;
    if (busy !== 1'b0 || error !== 1'b0 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL led_done: busy=%b error=%b init_done=%b, required 0 0 1", busy, error, init_done);
    end
    checks++;
    if (exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL led_cmdq: %0d sends pending, required 0", exp_cmd.size());
    end
  endtask

  task automatic test_retry_ok();
    repeat (4) exp_cmd.push_back(8'hED);
    exp_cmd.push_back(8'h02);
    pulse_led(3'b010);
    for (int i = 0; i < 3; i++) begin
      tx_ack("retry_ok");
      rx_byte(8'hFE);
    end
    tx_ack("retry_ok_last");
    rx_byte(8'hFA);
    tx_ack("retry_ok_arg");
    rx_byte(8'hFA);
    checks++;
    if (error !== 1'b0 || busy !== 1'b0 || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL retry_ok: error=%b busy=%b pending=%0d, required 0 0 0", error, busy, exp_cmd.size());
    end
  endtask

  task automatic test_retry_fail();
    repeat (4) exp_cmd.push_back(8'hED);
    pulse_led(3'b001);
    for (int i = 0; i < 3; i++) begin
      tx_ack("retry_fail");
      rx_byte(8'hFE);
      checks++;
      if (error !== 1'b0) begin errors++; $display("FAIL retry_fail_early: error=%b after FE %0d, required 0", error, i + 1); end
    end
    tx_ack("retry_fail_last");
    rx_byte(8'hFE);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || send_command !== 1'b0) begin
      errors++;
      $display("FAIL retry_fail: error=%b busy=%b send=%b, required 1 0 0", error, busy, send_command);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_cmd.size() != 0 || error !== 1'b1) begin
      errors++;
      $display("FAIL retry_fail_sticky: pending=%0d error=%b, required 0 1", exp_cmd.size(), error);
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_cmd.push_back(8'hFF);
    pulse_init();
    checks++;
    if (error !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_accept: error=%b init_done=%b, required 0 0", error, init_done);
    end
    tx_ack("timeout");
    n = 0;
    while (error !== 1'b1 && n < RSP_TO + 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != RSP_TO) begin
      errors++;
      $display("FAIL timeout_cycles: error rose after %0d cycles, required %0d", n, RSP_TO);
    end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: error=%b busy=%b, required 1 0", error, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_timeout();
    exp_cmd.push_back(8'hED);
    pulse_led(3'b111);
    wait_send("txto");
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL txto_busy: busy=%b error=%b, required 1 0", busy, error);
    end
    error_communication_timed_out = 1'b1;
    @(negedge clk) error_communication_timed_out = 1'b0;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || send_command !== 1'b0) begin
      errors++;
      $display("FAIL txto: error=%b busy=%b send=%b, required 1 0 0", error, busy, send_command);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bat_fail();
    exp_cmd.push_back(8'hFF);
    pulse_init();
    tx_ack("batfail");
    rx_byte(8'hFA);
    rx_byte(8'hFC);
    checks++;
    if (error !== 1'b1 || init_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bat_fail: error=%b init_done=%b busy=%b, required 1 0 0", error, init_done, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_passthrough();
    exp_cmd.push_back(8'hFF);
    pulse_init();
    tx_ack("pass");
    exp_key.push_back(8'h1C);
    rx_byte(8'h1C);
    checks++;
    if (key_data_en !== 1'b1 || key_data !== 8'h1C) begin
      errors++;
      $display("FAIL pass_fwd: key_en=%b key_data=%02h, required 1 1C", key_data_en, key_data);
    end
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL pass_seq: init_done=%b busy=%b error=%b, required 1 0 0", init_done, busy, error);
    end
  endtask

  task automatic test_idle_forward();
    logic [7:0] bytes [4];
    bytes[0] = 8'hFA; bytes[1] = 8'hFE; bytes[2] = 8'hAA; bytes[3] = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      exp_key.push_back(bytes[i]);
      rx_byte(bytes[i]);
    end
    @(negedge clk);
    checks++;
    if (exp_key.size() != 0 || busy !== 1'b0 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL idle_fwd: pending=%0d busy=%b init_done=%b, required 0 0 1", exp_key.size(), busy, init_done);
    end
  endtask

  task automatic test_back_to_back();
    exp_cmd.push_back(8'hFF);
    @(negedge clk) begin init_req = 1'b1; led_req = 1'b1; led_val = 3'b011; end
    @(negedge clk) begin init_req = 1'b0; led_req = 1'b0; end
    tx_ack("b2b");
    pulse_led(3'b110);
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    repeat (10) @(negedge clk);
    checks++;
    if (exp_cmd.size() != 0 || busy !== 1'b0 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b: pending=%0d busy=%b init_done=%b, required 0 0 1", exp_cmd.size(), busy, init_done);
    end
  endtask

  task automatic test_reset_mid();
    exp_cmd.push_back(8'hFF);
    pulse_init();
    wait_send("rstmid");
    resetn = 1'b0;
    #1;
    checks++;
    if (send_command !== 1'b0 || busy !== 1'b0 || the_command !== 8'h00 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: send=%b busy=%b cmd=%02h init_done=%b, required 0 0 00 0",
               send_command, busy, the_command, init_done);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (send_command !== 1'b0 || busy !== 1'b0 || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL rstmid_after: send=%b busy=%b pending=%0d, required 0 0 0", send_command, busy, exp_cmd.size());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_init();
    test_led();
    test_retry_ok();
    test_retry_fail();
    test_timeout();
    test_tx_timeout();
    test_bat_fail();
    test_passthrough();
    test_idle_forward();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
